// File: rtl/spart_echo_master.sv
// SPART bus initiator: programs the baud divisor after reset, then echoes every received
// byte back to the transmitter, optionally upper-casing ASCII letters on the way.
module spart_echo_master #(
    parameter logic [15:0] BAUD_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        upcase,
    input  logic        rx_q_empty,
    input  logic        tx_q_full,
    output logic        iocs_n,
    output logic        iorw_n,
    output logic [1:0]  ioaddr,
    inout  wire  [7:0]  databus,
    output logic [15:0] echo_cnt,
    output logic [7:0]  last_byte,
    output logic        busy
);

    typedef enum logic [2:0] {
        StInitLo,
        StInitHi,
        StIdle,
        StRdRx,
        StSettle,
        StWrTx
    } state_e;

    localparam logic [1:0] AddrBuf  = 2'b00;
    localparam logic [1:0] AddrDbLo = 2'b10;
    localparam logic [1:0] AddrDbHi = 2'b11;

    state_e      state_q, state_d;
    logic        iocs_n_q, iocs_n_d;
    logic        iorw_n_q, iorw_n_d;
    logic [1:0]  ioaddr_q, ioaddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] echo_cnt_q, echo_cnt_d;
    logic [7:0]  last_byte_q, last_byte_d;
    logic [7:0]  tx_byte;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StInitLo;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. StInitLo is also the reset state, so it only advances once its
    // write has actually been on the bus.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInitLo: if (!iocs_n_q) state_d = StInitHi;
            StInitHi: state_d = StIdle;
            StIdle:   if (en && !rx_q_empty && !tx_q_full) state_d = StRdRx;
            StRdRx:   state_d = StSettle;
            StSettle: if (!tx_q_full) state_d = StWrTx;
            StWrTx:   state_d = StIdle;
            default:  state_d = StInitLo;
        endcase
    end

    always_comb begin
        tx_byte = hold_q;
        if (upcase && (hold_q >= 8'h61) && (hold_q <= 8'h7A)) begin
            tx_byte = hold_q - 8'h20;
        end
    end

    // Output logic: bus signals are decoded from the next state so the registered bus
    // lines up with the state that owns the access.
    always_comb begin
        iocs_n_d = 1'b1;
        iorw_n_d = iorw_n_q;
        ioaddr_d = ioaddr_q;
        wdata_d  = wdata_q;
        unique case (state_d)
            StInitLo: begin
                iocs_n_d = 1'b0;
                iorw_n_d = 1'b0;
                ioaddr_d = AddrDbLo;
                wdata_d  = BAUD_DIV[7:0];
            end
            StInitHi: begin
                iocs_n_d = 1'b0;
                iorw_n_d = 1'b0;
                ioaddr_d = AddrDbHi;
                wdata_d  = BAUD_DIV[15:8];
            end
            StRdRx: begin
                iocs_n_d = 1'b0;
                iorw_n_d = 1'b1;
                ioaddr_d = AddrBuf;
            end
            StWrTx: begin
                iocs_n_d = 1'b0;
                iorw_n_d = 1'b0;
                ioaddr_d = AddrBuf;
                wdata_d  = tx_byte;
            end
            default: ;
        endcase

        hold_d      = (state_q == StRdRx) ? databus : hold_q;
        echo_cnt_d  = echo_cnt_q;
        last_byte_d = last_byte_q;
        if (state_q == StWrTx) begin
            echo_cnt_d  = echo_cnt_q + 16'd1;
            last_byte_d = wdata_q;
        end
        busy = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iocs_n_q    <= 1'b1;
            iorw_n_q    <= 1'b1;
            ioaddr_q    <= 2'b00;
            wdata_q     <= 8'h00;
            hold_q      <= 8'h00;
            echo_cnt_q  <= 16'h0000;
            last_byte_q <= 8'h00;
        end else begin
            iocs_n_q    <= iocs_n_d;
            iorw_n_q    <= iorw_n_d;
            ioaddr_q    <= ioaddr_d;
            wdata_q     <= wdata_d;
            hold_q      <= hold_d;
            echo_cnt_q  <= echo_cnt_d;
            last_byte_q <= last_byte_d;
        end
    end

    assign iocs_n    = iocs_n_q;
    assign iorw_n    = iorw_n_q;
    assign ioaddr    = ioaddr_q;
    assign echo_cnt  = echo_cnt_q;
    assign last_byte = last_byte_q;
    assign databus   = (!iocs_n_q && !iorw_n_q) ? wdata_q : 8'hzz;

endmodule
